// File: rtl/ltc2174_frame_deser_pkg.sv
// Shared constants, FSM encoding and bit-map helper for the LTC2174
// 2-lane / 16-bit serialization frame deserializer.
package ltc2174_pkg;

  localparam int SAMPLES_PER_FRAME = 8;
  localparam int ADC_BITS          = 14;
  localparam int NUM_CH            = 4;
  localparam int HIST_LEN          = 16;
  localparam int SLIP_W            = 3;

  localparam logic [SAMPLES_PER_FRAME-1:0] FRAME_PAT = 8'b1111_0000;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef logic [SAMPLES_PER_FRAME-1:0] window_t;
  typedef logic [ADC_BITS-1:0]          sample_t;

  // Lane A carries the odd bits D13..D1 and lane B the even bits D12..D0,
  // both oldest-first; the trailing pad sample is stripped by the caller.
  function automatic sample_t assemble(input logic [6:0] lane_a,
                                       input logic [6:0] lane_b);
    return {lane_a[6], lane_b[6], lane_a[5], lane_b[5],
            lane_a[4], lane_b[4], lane_a[3], lane_b[3],
            lane_a[2], lane_b[2], lane_a[1], lane_b[1],
            lane_a[0], lane_b[0]};
  endfunction

endpackage

// File: rtl/ltc2174_frame_deser_lane_window_sel.sv
// One serial line: 16-sample history (two samples per clock, rise then fall)
// and an 8-sample window that ends `slip` samples before the newest sample.
module lane_window_sel
  import ltc2174_pkg::*;
(
  input  logic              clk,
  input  logic              sample_r_i,
  input  logic              sample_f_i,
  input  logic [SLIP_W-1:0] slip_i,
  output window_t           window_o
);

  localparam int BASE_W = $clog2(HIST_LEN);

  logic [HIST_LEN-3:0] hist_q;
  logic [HIST_LEN-1:0] hist_d;
  logic [BASE_W-1:0]   base;

  // Bit 0 is the newest sample, so the current cycle's pair joins the window
  // in the same cycle it is captured.
  assign hist_d   = {hist_q, sample_r_i, sample_f_i};
  assign base     = {1'b0, slip_i};
  assign window_o = hist_d[base +: SAMPLES_PER_FRAME];

  // NOTE: the history has no reset on purpose; after rst it is don't-care and
  // is overwritten by fresh samples before any slip value can select it.
  always_ff @(posedge clk) begin
    hist_q <= hist_d[HIST_LEN-3:0];
  end

endmodule

// File: rtl/ltc2174_frame_deser.sv
// LTC2174 receive-side word assembler: frame alignment hunt/lock FSM and
// parallel 14-bit sample output for four channels over two lanes.
module ltc2174_frame_deser
  import ltc2174_pkg::*;
#(
  parameter logic [3:0]  REVERSE_A  = 4'b1111,
  parameter logic [3:0]  REVERSE_B  = 4'b1111,
  parameter logic        REVERSE_F  = 1'b1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_r,
  input  logic        frame_f,
  input  logic [3:0]  adca_r,
  input  logic [3:0]  adca_f,
  input  logic [3:0]  adcb_r,
  input  logic [3:0]  adcb_f,
  output logic [13:0] dout1,
  output logic [13:0] dout2,
  output logic [13:0] dout3,
  output logic [13:0] dout4,
  output logic        dout_valid,
  output logic        locked,
  output logic [7:0]  frame_err
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_LIM  = 4'(ERR_LIMIT);

  // Polarity-corrected inputs
  logic              frame_r_p, frame_f_p;
  logic [NUM_CH-1:0] adca_r_p, adca_f_p, adcb_r_p, adcb_f_p;

  assign frame_r_p = frame_r ^ REVERSE_F;
  assign frame_f_p = frame_f ^ REVERSE_F;
  assign adca_r_p  = adca_r ^ REVERSE_A;
  assign adca_f_p  = adca_f ^ REVERSE_A;
  assign adcb_r_p  = adcb_r ^ REVERSE_B;
  assign adcb_f_p  = adcb_f ^ REVERSE_B;

  // State
  state_e                   state_q;
  logic [1:0]               phase_q;
  logic [SLIP_W-1:0]        slip_q;
  logic [3:0]               good_q;
  logic [3:0]               bad_q;
  logic [7:0]               frame_err_q;
  logic                     locked_q;
  logic                     dout_valid_q;
  logic [NUM_CH-1:0][ADC_BITS-1:0] dout_q;

  // Window selection
  window_t                         frame_win;
  logic [NUM_CH-1:0][ADC_BITS-1:0] asm_w;
  logic [NUM_CH-1:0]               pad_w;
  logic                            pad_unused;
  logic                            frame_match;

  lane_window_sel u_frame (
    .clk        (clk),
    .sample_r_i (frame_r_p),
    .sample_f_i (frame_f_p),
    .slip_i     (slip_q),
    .window_o   (frame_win)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    window_t win_a, win_b;

    lane_window_sel u_lane_a (
      .clk        (clk),
      .sample_r_i (adca_r_p[ch]),
      .sample_f_i (adca_f_p[ch]),
      .slip_i     (slip_q),
      .window_o   (win_a)
    );

    lane_window_sel u_lane_b (
      .clk        (clk),
      .sample_r_i (adcb_r_p[ch]),
      .sample_f_i (adcb_f_p[ch]),
      .slip_i     (slip_q),
      .window_o   (win_b)
    );

    assign asm_w[ch] = assemble(win_a[7:1], win_b[7:1]);
    assign pad_w[ch] = win_a[0] ^ win_b[0];
  end

  // Pad samples carry no data
  assign pad_unused  = ^pad_w;
  assign frame_match = (frame_win == FRAME_PAT);

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      phase_q      <= 2'd0;
      slip_q       <= '0;
      good_q       <= 4'd0;
      bad_q        <= 4'd0;
      frame_err_q  <= 8'd0;
      locked_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      phase_q      <= phase_q + 2'd1;
      dout_valid_q <= 1'b0;

      if (phase_q == 2'd3) begin
        unique case (state_q)
          HUNT: begin
            if (frame_match) begin
              good_q <= 4'd1;
              if (LOCK_CNT == 4'd1) begin
                state_q      <= LOCKED;
                locked_q     <= 1'b1;
                dout_q       <= asm_w;
                dout_valid_q <= 1'b1;
              end else begin
                state_q <= CHECK;
              end
            end else begin
              slip_q <= slip_q + 3'd1;
            end
          end

          CHECK: begin
            if (frame_match) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_CNT) begin
                state_q      <= LOCKED;
                locked_q     <= 1'b1;
                dout_q       <= asm_w;
                dout_valid_q <= 1'b1;
              end
            end else begin
              state_q <= HUNT;
              good_q  <= 4'd0;
              slip_q  <= slip_q + 3'd1;
            end
          end

          LOCKED: begin
            if (frame_match) begin
              bad_q        <= 4'd0;
              dout_q       <= asm_w;
              dout_valid_q <= 1'b1;
            end else begin
              if (frame_err_q != 8'hFF) frame_err_q <= frame_err_q + 8'd1;
              // The limiting bad frame drops lock without a strobe; slip is kept.
              if (bad_q + 4'd1 == ERR_LIM) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                bad_q    <= 4'd0;
                good_q   <= 4'd0;
              end else begin
                bad_q        <= bad_q + 4'd1;
                dout_q       <= asm_w;
                dout_valid_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout1      = dout_q[0];
  assign dout2      = dout_q[1];
  assign dout3      = dout_q[2];
  assign dout4      = dout_q[3];
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ltc2174_frame_deser.sv
// Directed bench for ltc2174_frame_deser: builds serial frame streams from
// 14-bit words and checks lock timing, data, error counting and reset.
module tb_ltc2174_frame_deser;

  localparam logic [3:0] REV_A = 4'b1111;
  localparam logic [3:0] REV_B = 4'b1111;
  localparam logic       REV_F = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_r = 1'b0, frame_f = 1'b0;
  logic [3:0]  adca_r = '0, adca_f = '0, adcb_r = '0, adcb_f = '0;
  logic [13:0] dout1, dout2, dout3, dout4;
  logic        dout_valid, locked;
  logic [7:0]  frame_err;

  always #5 clk = ~clk;

  ltc2174_frame_deser dut (
    .clk        (clk),
    .rst        (rst),
    .frame_r    (frame_r),
    .frame_f    (frame_f),
    .adca_r     (adca_r),
    .adca_f     (adca_f),
    .adcb_r     (adcb_r),
    .adcb_f     (adcb_f),
    .dout1      (dout1),
    .dout2      (dout2),
    .dout3      (dout3),
    .dout4      (dout4),
    .dout_valid (dout_valid),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  typedef struct {
    int          cyc;
    logic [13:0] d1, d2, d3, d4;
  } word_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          first_lock  = -1;
  logic        fq[$];
  logic [3:0]  aq[$];
  logic [3:0]  bq[$];
  word_t       vq[$];
  logic [7:0]  pat = 8'b1111_0000;
  logic [7:0]  bad_pat = 8'b1110_0000;

  // ---------------------------------------------------------------- stimulus
  task automatic pop_sample(output logic f, output logic [3:0] a, output logic [3:0] b);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      a = aq.pop_front();
      b = bq.pop_front();
    end else begin
      f = 1'b0;
      a = 4'h0;
      b = 4'h0;
    end
  endtask

  task automatic tick();
    logic       f0, f1;
    logic [3:0] a0, a1, b0, b1;
    word_t      w;
    pop_sample(f0, a0, b0);
    pop_sample(f1, a1, b1);
    frame_r = f0 ^ REV_F;
    frame_f = f1 ^ REV_F;
    adca_r  = a0 ^ REV_A;
    adca_f  = a1 ^ REV_A;
    adcb_r  = b0 ^ REV_B;
    adcb_f  = b1 ^ REV_B;
    @(posedge clk);
    #1;
    cyc++;
    if (locked === 1'b1 && first_lock < 0) first_lock = cyc;
    if (dout_valid === 1'b1) begin
      w.cyc = cyc;
      w.d1  = dout1;
      w.d2  = dout2;
      w.d3  = dout3;
      w.d4  = dout4;
      vq.push_back(w);
    end
  endtask

  task automatic do_reset();
    fq.delete();
    aq.delete();
    bq.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    first_lock = -1;
    vq.delete();
  endtask

  // Serialise one frame: lane A = D13,D11..D1,pad; lane B = D12,D10..D0,pad.
  task automatic push_frame(input logic [13:0] v1, input logic [13:0] v2,
                            input logic [13:0] v3, input logic [13:0] v4,
                            input logic [7:0] fp);
    logic [13:0] v[4];
    logic [3:0]  a, b;
    v[0] = v1; v[1] = v2; v[2] = v3; v[3] = v4;
    for (int k = 0; k < 8; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (k < 7) begin
          a[ch] = v[ch][13-2*k];
          b[ch] = v[ch][12-2*k];
        end else begin
          a[ch] = 1'b1;
          b[ch] = 1'b1;
        end
      end
      fq.push_back(fp[7-k]);
      aq.push_back(a);
      bq.push_back(b);
    end
  endtask

  // Last p samples of an idle frame, so the stream stays periodic.
  task automatic push_prefix(input int p);
    for (int k = 8 - p; k < 8; k++) begin
      fq.push_back(pat[7-k]);
      aq.push_back(4'h0);
      bq.push_back(4'h0);
    end
  endtask

  function automatic logic [13:0] sweep_val(input int ch, input int f);
    return 14'((ch + 1) * 1024 + f);
  endfunction

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    vectors++; if (dout1 !== 14'h0) begin miscompares++; $display("FAIL reset_dout1: got %h want 0000", dout1); end
    vectors++; if (dout2 !== 14'h0) begin miscompares++; $display("FAIL reset_dout2: got %h want 0000", dout2); end
    vectors++; if (dout3 !== 14'h0) begin miscompares++; $display("FAIL reset_dout3: got %h want 0000", dout3); end
    vectors++; if (dout4 !== 14'h0) begin miscompares++; $display("FAIL reset_dout4: got %h want 0000", dout4); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
    vectors++; if (frame_err !== 8'h0) begin miscompares++; $display("FAIL reset_frame_err: got %0d want 0", frame_err); end
  endtask

  task automatic test_aligned();
    do_reset();
    for (int f = 0; f < 8; f++) push_frame(14'h003E, 14'h1555, 14'h2AAA, 14'h0001, pat);
    repeat (32) tick();
    vectors++;
    if (first_lock != 16) begin miscompares++; $display("FAIL aligned_lock_cycle: got %0d want 16", first_lock); end
    vectors++;
    if (vq.size() != 5) begin miscompares++; $display("FAIL aligned_valid_count: got %0d want 5", vq.size()); end
    for (int i = 0; i < vq.size(); i++) begin
      vectors++;
      if (vq[i].cyc != 16 + 4*i) begin
        miscompares++; $display("FAIL aligned_valid_cycle[%0d]: got %0d want %0d", i, vq[i].cyc, 16 + 4*i);
      end
      vectors++;
      if (vq[i].d1 !== 14'h003E || vq[i].d2 !== 14'h1555 || vq[i].d3 !== 14'h2AAA || vq[i].d4 !== 14'h0001) begin
        miscompares++;
        $display("FAIL aligned_data[%0d]: got %h %h %h %h want 003e 1555 2aaa 0001",
                 i, vq[i].d1, vq[i].d2, vq[i].d3, vq[i].d4);
      end
    end
  endtask

  task automatic test_slip_sweep();
    for (int d = 0; d < 8; d++) begin
      int nf, ticks, exp_first, exp_last, exp_cyc;
      do_reset();
      nf        = d + 6;
      ticks     = (d == 0) ? 24 : 4*d + 28;
      exp_first = (d == 0) ? 3 : d + 2;
      exp_last  = d + 5;
      exp_cyc   = 4*(d + 3) + 4;
      push_prefix((8 - d) % 8);
      for (int f = 0; f < nf; f++)
        push_frame(sweep_val(0, f), sweep_val(1, f), sweep_val(2, f), sweep_val(3, f), pat);
      repeat (ticks) tick();
      vectors++;
      if (first_lock != exp_cyc) begin
        miscompares++; $display("FAIL slip%0d_lock_cycle: got %0d want %0d", d, first_lock, exp_cyc);
      end
      vectors++;
      if (vq.size() != exp_last - exp_first + 1) begin
        miscompares++; $display("FAIL slip%0d_valid_count: got %0d want %0d", d, vq.size(), exp_last - exp_first + 1);
      end
      for (int i = 0; i < vq.size(); i++) begin
        vectors++;
        if (vq[i].cyc != exp_cyc + 4*i ||
            vq[i].d1 !== sweep_val(0, exp_first + i) || vq[i].d2 !== sweep_val(1, exp_first + i) ||
            vq[i].d3 !== sweep_val(2, exp_first + i) || vq[i].d4 !== sweep_val(3, exp_first + i)) begin
          miscompares++;
          $display("FAIL slip%0d_word[%0d]: got cyc %0d %h %h %h %h want cyc %0d %h %h %h %h", d, i,
                   vq[i].cyc, vq[i].d1, vq[i].d2, vq[i].d3, vq[i].d4, exp_cyc + 4*i,
                   sweep_val(0, exp_first + i), sweep_val(1, exp_first + i),
                   sweep_val(2, exp_first + i), sweep_val(3, exp_first + i));
        end
      end
    end
  endtask

  task automatic test_single_bad_frame();
    do_reset();
    for (int f = 0; f < 9; f++)
      push_frame(14'h0ABC, 14'h1DEF, 14'h2345, 14'h3210, (f == 6) ? bad_pat : pat);
    repeat (36) tick();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL single_bad_locked: got %b want 1", locked); end
    vectors++; if (frame_err !== 8'd1) begin miscompares++; $display("FAIL single_bad_frame_err: got %0d want 1", frame_err); end
    vectors++; if (vq.size() != 6) begin miscompares++; $display("FAIL single_bad_valid_count: got %0d want 6", vq.size()); end
    if (vq.size() > 3) begin
      vectors++;
      if (vq[3].cyc != 28 || vq[3].d1 !== 14'h0ABC || vq[3].d4 !== 14'h3210) begin
        miscompares++;
        $display("FAIL single_bad_word: got cyc %0d %h %h want cyc 28 0abc 3210", vq[3].cyc, vq[3].d1, vq[3].d4);
      end
    end
  endtask

  task automatic test_double_bad_frame();
    do_reset();
    for (int f = 0; f < 11; f++)
      push_frame(14'h0111, 14'h0222, 14'h0333, 14'h0444, (f == 5 || f == 6) ? bad_pat : pat);
    repeat (24) tick();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL double_bad_first_locked: got %b want 1", locked); end
    vectors++; if (frame_err !== 8'd1) begin miscompares++; $display("FAIL double_bad_first_err: got %0d want 1", frame_err); end
    repeat (4) tick();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL double_bad_locked: got %b want 0", locked); end
    vectors++; if (frame_err !== 8'd2) begin miscompares++; $display("FAIL double_bad_frame_err: got %0d want 2", frame_err); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL double_bad_no_strobe: got %b want 0", dout_valid); end
    vectors++; if (vq.size() != 3) begin miscompares++; $display("FAIL double_bad_valid_count: got %0d want 3", vq.size()); end
    repeat (16) tick();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL double_bad_relock: got %b want 1", locked); end
    vectors++; if (frame_err !== 8'd2) begin miscompares++; $display("FAIL double_bad_err_kept: got %0d want 2", frame_err); end
  endtask

  task automatic test_no_pattern();
    do_reset();
    repeat (64) tick();
    vectors++; if (first_lock != -1) begin miscompares++; $display("FAIL no_pattern_lock: got cycle %0d want none", first_lock); end
    vectors++; if (vq.size() != 0) begin miscompares++; $display("FAIL no_pattern_valid: got %0d strobes want 0", vq.size()); end
  endtask

  task automatic test_rst_while_locked();
    do_reset();
    for (int f = 0; f < 14; f++)
      push_frame(14'h1234, 14'h2345, 14'h3456, 14'h0567, (f >= 4 && f <= 12 && f % 2 == 0) ? bad_pat : pat);
    repeat (56) tick();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rst_pre_locked: got %b want 1", locked); end
    vectors++; if (frame_err !== 8'd5) begin miscompares++; $display("FAIL rst_pre_frame_err: got %0d want 5", frame_err); end
    vectors++; if (dout1 !== 14'h1234) begin miscompares++; $display("FAIL rst_pre_dout1: got %h want 1234", dout1); end
    do_reset();
    vectors++;
    if (dout1 !== 14'h0 || dout2 !== 14'h0 || dout3 !== 14'h0 || dout4 !== 14'h0) begin
      miscompares++; $display("FAIL rst_dout: got %h %h %h %h want 0000 x4", dout1, dout2, dout3, dout4);
    end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked: got %b want 0", locked); end
    vectors++; if (frame_err !== 8'd0) begin miscompares++; $display("FAIL rst_frame_err: got %0d want 0", frame_err); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    for (int f = 0; f < 4; f++) push_frame(14'h2001, 14'h0FF0, 14'h3C3C, 14'h1248, pat);
    repeat (16) tick();
    vectors++; if (first_lock != 16) begin miscompares++; $display("FAIL rst_relock_cycle: got %0d want 16", first_lock); end
    vectors++;
    if (vq.size() != 1) begin
      miscompares++; $display("FAIL rst_relock_valid_count: got %0d want 1", vq.size());
    end else if (vq[0].d1 !== 14'h2001 || vq[0].d2 !== 14'h0FF0 || vq[0].d3 !== 14'h3C3C || vq[0].d4 !== 14'h1248) begin
      miscompares++;
      $display("FAIL rst_relock_data: got %h %h %h %h want 2001 0ff0 3c3c 1248", vq[0].d1, vq[0].d2, vq[0].d3, vq[0].d4);
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int f = 0; f < 40; f++)
      push_frame(14'(f), 14'(14'h0FF0 + f), 14'(14'h1FF0 + f), 14'(14'h3FD8 + f), pat);
    repeat (160) tick();
    vectors++;
    if (vq.size() != 37) begin miscompares++; $display("FAIL ramp_valid_count: got %0d want 37", vq.size()); end
    for (int i = 0; i < vq.size(); i++) begin
      logic [13:0] e1, e2, e3, e4;
      e1 = 14'(3 + i);
      e2 = 14'(14'h0FF0 + 3 + i);
      e3 = 14'(14'h1FF0 + 3 + i);
      e4 = 14'(14'h3FD8 + 3 + i);
      vectors++;
      if (vq[i].d1 !== e1 || vq[i].d2 !== e2 || vq[i].d3 !== e3 || vq[i].d4 !== e4 || vq[i].cyc != 16 + 4*i) begin
        miscompares++;
        $display("FAIL ramp_word[%0d]: got cyc %0d %h %h %h %h want cyc %0d %h %h %h %h", i,
                 vq[i].cyc, vq[i].d1, vq[i].d2, vq[i].d3, vq[i].d4, 16 + 4*i, e1, e2, e3, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_slip_sweep();
    test_single_bad_frame();
    test_double_bad_frame();
    test_no_pattern();
    test_rst_while_locked();
    test_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
